// File: rtl/imem_boot_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
//   ldr_state_e : loader FSM states
//   HDR_BYTES   : length-header size in bytes (little-endian word count)
//   word_addr() : byte address of a word index relative to a base address
package imem_boot_pkg;

  typedef enum logic [2:0] {BOOT, HDR, DATA, DONE, ERR} ldr_state_e;

  localparam int HDR_BYTES = 2;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [29:0] idx);
    return base + {idx, 2'b00};
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous restart of the byte position (drops a partial word)
//   valid, data : byte strobe and byte value
//   word        : assembled word, meaningful while word_ready is high
//   word_ready  : high in the cycle the fourth byte of a word is presented
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shift_q, shift_d;

  // New bytes enter at the top and move down, so after four bytes the first
  // one received sits in bits [7:0].
  assign word       = {data, shift_q[31:8]};
  assign word_ready = valid && (byte_idx_q == 2'd3);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    if (clear) begin
      byte_idx_d = 2'd0;
      shift_d    = '0;
    end else if (valid) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shift_d    = word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop sample its _d value from
    // before the edge, regardless of statement order across blocks.
    if (!rst_n) begin
      byte_idx_q <= 2'd0;
      shift_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: receives a 2-byte little-endian word count
// followed by the image bytes, writes each assembled word to the instruction
// memory and holds the core in reset until the image is complete.
//   i_clk, i_reset          : clock, asynchronous active-low reset
//   i_boot_en               : 1 = load an image after reset, 0 = run preloaded image
//   i_start                 : restart a load from DONE or ERR
//   i_rx_data/valid, o_rx_ready : byte stream handshake
//   o_wr_en/addr/data       : instruction memory write port
//   o_cpu_rst_n             : core reset, released only in DONE
//   o_busy/o_done/o_err     : loader status
//   o_word_cnt              : words written in the current load
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int          DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_boot_en,
  input  logic             i_start,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_rx_ready,
  output logic             o_wr_en,
  output logic [31:0]      o_wr_addr,
  output logic [31:0]      o_wr_data,
  output logic             o_cpu_rst_n,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_word_cnt
);

  ldr_state_e       state_q, state_d;
  logic             hdr_cnt_q, hdr_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             rx_ready_q, rx_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;

  logic             accept;
  logic             pk_clear;
  logic [31:0]      pk_word;
  logic             pk_word_ready;
  logic [CNT_W-1:0] hdr_len;

  // Ready is a registered copy of "next state is HDR or DATA", so it is
  // already low in the first DONE/ERR cycle and no stray byte is consumed.
  assign accept  = i_rx_valid && rx_ready_q;
  assign hdr_len = CNT_W'({i_rx_data, len_q[7:0]});

  byte_word_packer u_packer (
    .clk        (i_clk),
    .rst_n      (i_reset),
    .clear      (pk_clear),
    .valid      (accept && (state_q == DATA)),
    .data       (i_rx_data),
    .word       (pk_word),
    .word_ready (pk_word_ready)
  );

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pk_clear   = 1'b0;

    unique case (state_q)
      BOOT: state_d = i_boot_en ? HDR : DONE;

      HDR: begin
        if (accept) begin
          if (hdr_cnt_q != 1'(HDR_BYTES - 1)) begin
            len_d[7:0] = i_rx_data;
            hdr_cnt_d  = 1'b1;
          end else begin
            hdr_cnt_d = 1'b0;
            len_d     = hdr_len;
            if (hdr_len == '0)                     state_d = DONE;
            else if (32'(hdr_len) > 32'(DEPTH))    state_d = ERR;
            else                                   state_d = DATA;
          end
        end
      end

      DATA: begin
        // The count reaches len on the edge of the last write; finishing one
        // cycle later leaves o_done high in the cycle after that write.
        if (word_cnt_q == len_q) begin
          state_d = DONE;
        end else if (pk_word_ready) begin
          wr_en_d    = 1'b1;
          wr_data_d  = pk_word;
          wr_addr_d  = word_addr(BASE_ADDR, 30'(word_cnt_q));
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end

      DONE, ERR: begin
        if (i_start) begin
          state_d    = HDR;
          hdr_cnt_d  = 1'b0;
          len_d      = '0;
          word_cnt_d = '0;
          wr_addr_d  = BASE_ADDR;
          pk_clear   = 1'b1;
        end
      end

      default: state_d = BOOT;
    endcase

    rx_ready_d  = (state_d == HDR) || (state_d == DATA);
    busy_d      = rx_ready_d;
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
    cpu_rst_n_d = done_d;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= BOOT;
      hdr_cnt_q   <= 1'b0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      wr_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign o_rx_ready  = rx_ready_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_cpu_rst_n = cpu_rst_n_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: header table, hand-written
// corner-case sequences and randomized images against a behavioural model.
module tb_imem_boot_loader;

  localparam int          DEPTH = 2048;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             boot_en = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             o_rx_ready, o_wr_en, o_cpu_rst_n, o_busy, o_done, o_err;
  logic [31:0]      o_wr_addr, o_wr_data;
  logic [CNT_W-1:0] o_word_cnt;

  imem_boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_boot_en   (boot_en),
    .i_start     (start),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_cpu_rst_n (o_cpu_rst_n),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_word_cnt  (o_word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         wr_log[$];
  logic [63:0] exp_wr[$];
  logic [7:0]  img[$];
  logic        prev_wr = 1'b0;

  // Write monitor: logs every strobe and flags back-to-back strobes.
  always @(negedge clk) begin
    if (rst_n && o_wr_en) begin
      wr_log.push_back('{o_wr_addr, o_wr_data, cyc});
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL wr_en_back_to_back: wr_en high two cycles in a row at cycle %0d, required single pulse", cyc);
      end
    end
    prev_wr = rst_n && o_wr_en;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_flags"}, 32'({o_rx_ready, o_wr_en, o_busy, o_done, o_err, o_cpu_rst_n}), 32'h0);
    check({name, "_addr"}, o_wr_addr, BASE);
    check({name, "_data"}, o_wr_data, 32'h0);
    check({name, "_cnt"}, 32'(o_word_cnt), 32'h0);
  endtask

  task automatic do_reset(input logic en);
    rst_n = 1'b0; boot_en = en; start = 1'b0; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte after an optional random gap; start noise may be
  // sprinkled into the gap cycles while the loader is busy.
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit noise);
    int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    int n = 0;
    for (int i = 0; i < gap; i++) begin
      start = noise && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    while (!o_rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_rx_ready) begin
      check("rx_ready_timeout", 32'(o_rx_ready), 32'h1);
      return;
    end
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  // Reference: the header gives the word count; legal images produce one
  // write per word at BASE + 4*i with the four bytes in little-endian order.
  task automatic build_expect();
    int len = int'({img[1], img[0]});
    exp_wr.delete();
    if (len == 0 || len > DEPTH) return;
    for (int w = 0; w < len; w++) begin
      int p = 2 + 4 * w;
      exp_wr.push_back({BASE + 32'(4 * w), img[p+3], img[p+2], img[p+1], img[p]});
    end
  endtask

  task automatic run_image(input string name, input int max_gap, input bit noise);
    int n = 0;
    int unsigned done_cyc;
    wr_log.delete();
    build_expect();
    foreach (img[i]) send_byte(img[i], max_gap, noise);
    while (!(o_done || o_err) && n < 100) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    check({name, "_done"}, 32'(o_done), 32'h1);
    check({name, "_cpu_rst_n"}, 32'(o_cpu_rst_n), 32'h1);
    check({name, "_word_cnt"}, 32'(o_word_cnt), 32'(exp_wr.size()));
    check({name, "_num_writes"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      check($sformatf("%s_addr[%0d]", name, i), wr_log[i].addr, exp_wr[i][63:32]);
      check($sformatf("%s_data[%0d]", name, i), wr_log[i].data, exp_wr[i][31:0]);
    end
    if (wr_log.size() > 0)
      check({name, "_done_latency"}, done_cyc - wr_log[$].cyc, 32'd1);
  endtask

  task automatic load_image2();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       exp_done;
    logic       exp_err;
    logic       exp_busy;
  } hdr_vec_t;

  hdr_vec_t hv[6];

  initial begin
    hv[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0};  // len 0: nothing to load
    hv[1] = '{8'h01, 8'h08, 1'b0, 1'b1, 1'b0};  // len 2049: too long
    hv[2] = '{8'h00, 8'h08, 1'b0, 1'b0, 1'b1};  // len 2048: largest legal
    hv[3] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0};
    hv[4] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1};
    hv[5] = '{8'h00, 8'h09, 1'b0, 1'b1, 1'b0};

    // Reset values while reset is held.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");

    // 1: preloaded image -> DONE one cycle after reset release, no writes.
    wr_log.delete();
    do_reset(1'b0);
    @(negedge clk);
    check("noboot_done", 32'(o_done), 32'h1);
    check("noboot_cpu_rst_n", 32'(o_cpu_rst_n), 32'h1);
    check("noboot_ready", 32'(o_rx_ready), 32'h0);
    repeat (5) @(negedge clk);
    check("noboot_writes", 32'(wr_log.size()), 32'h0);

    // Header decisions from the table.
    for (int v = 0; v < 6; v++) begin
      do_reset(1'b1);
      send_byte(hv[v].lo, 0, 1'b0);
      send_byte(hv[v].hi, 0, 1'b0);
      check($sformatf("hdr%0d_done", v), 32'(o_done), 32'(hv[v].exp_done));
      check($sformatf("hdr%0d_err", v), 32'(o_err), 32'(hv[v].exp_err));
      check($sformatf("hdr%0d_busy", v), 32'(o_busy), 32'(hv[v].exp_busy));
      check($sformatf("hdr%0d_cpu_rst_n", v), 32'(o_cpu_rst_n), 32'(hv[v].exp_done));
    end

    // 2: two-word image, back-to-back bytes.
    do_reset(1'b1);
    load_image2();
    run_image("img2", 0, 1'b0);

    // 3: oversize header -> sticky ERR, restart, empty image; then a start
    // coincident with a valid byte in DONE must not consume that byte.
    do_reset(1'b1);
    wr_log.delete();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h08, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("err_sticky", 32'(o_err), 32'h1);
    check("err_cpu_rst_n", 32'(o_cpu_rst_n), 32'h0);
    check("err_ready", 32'(o_rx_ready), 32'h0);
    check("err_writes", 32'(wr_log.size()), 32'h0);
    pulse_start();
    check("err_restart_err", 32'(o_err), 32'h0);
    check("err_restart_busy", 32'(o_busy), 32'h1);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    check("empty_done", 32'(o_done), 32'h1);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hAB;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    check("restart_cpu_rst_n", 32'(o_cpu_rst_n), 32'h0);
    check("restart_busy", 32'(o_busy), 32'h1);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    check("restart_byte_not_consumed", 32'(o_done), 32'h1);

    // 4: same image with random gaps.
    do_reset(1'b1);
    load_image2();
    run_image("img2_gaps", 5, 1'b0);

    // 5: reset after three of four data bytes, then a clean reload.
    do_reset(1'b1);
    wr_log.delete();
    foreach (img[i]) if (i < 5) send_byte(img[i], 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midload_reset");
    check("midload_writes", 32'(wr_log.size()), 32'h0);
    do_reset(1'b1);
    run_image("img2_reload", 0, 1'b0);

    // Random legal images chained through i_start, with start noise while busy.
    do_reset(1'b1);
    for (int r = 0; r < 6; r++) begin
      int len = int'($urandom_range(1, 6));
      img.delete();
      img.push_back(8'(len));
      img.push_back(8'h00);
      for (int k = 0; k < 4 * len; k++) img.push_back(8'($urandom));
      run_image($sformatf("rand%0d", r), 3, 1'b1);
      pulse_start();
      check($sformatf("rand%0d_restart_cnt", r), 32'(o_word_cnt), 32'h0);
      check($sformatf("rand%0d_restart_cpu_rst_n", r), 32'(o_cpu_rst_n), 32'h0);
    end

    // 6: full-depth image.
    do_reset(1'b1);
    img.delete();
    img.push_back(8'h00);
    img.push_back(8'h08);
    for (int k = 0; k < 4 * DEPTH; k++) img.push_back(8'($urandom));
    run_image("full", 0, 1'b0);
    if (wr_log.size() > 0) check("full_last_addr", wr_log[$].addr, 32'h0000_1FFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
